// File: rtl/ifu_fetch_queue.sv
// Instruction fetch stage: issues word fetches under a credit limit, queues in-order
// responses with their PCs for decode, and drops stale responses after a redirect.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_idle
);

    localparam int unsigned PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    fq_entry_t        fq_q [QDEPTH];

    logic        credit_ok;
    logic        req_fire;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsb;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Credit counts both queued entries and requests still in flight (stale ones included).
    assign credit_ok       = (SUM_W'(occ_q) + SUM_W'(outst_q)) < SUM_W'(QDEPTH);
    assign imem_req_valid  = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr   = fetch_pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign rsp_drop        = imem_rsp_valid && (disc_q != '0);
    assign push            = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign pop             = (occ_q != '0) && if_ready && !redirect_valid;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign if_valid = (occ_q != '0);
    assign if_pc    = fq_q[head_q].pc;
    assign if_inst  = fq_q[head_q].inst;
    assign if_idle  = (occ_q == '0) && (outst_q == '0) && (disc_q == '0);

    // Next-state for PCs, pointers and counters; redirect overrides everything else.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        occ_d      = occ_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        disc_d     = disc_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            // Whatever is still in flight after this cycle belongs to the old path.
            disc_d     = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                disc_d = disc_q - CNT_W'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                tail_d   = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            disc_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage is cleared on reset so the head reads as zero until the first fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            fq_q <= '{default: '0};
        end else if (push) begin
            fq_q[tail_q] <= '{pc: rsp_pc_q, inst: imem_rsp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!push || (occ_q < CNT_W'(QDEPTH)));
            assert (!imem_rsp_valid || (outst_q != '0));
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: reactive memory model plus a tagged in-flight/queue reference,
// directed scenarios and a randomized run.
module tb_ifu_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_idle;

    always #5 clk = ~clk;

    ifu_fetch_queue #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (2),
        .CNT_W    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_idle        (if_idle)
    );

    // In-flight request: the PC the model expects, the address memory actually saw.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        int          due;
        bit          stale;
    } fl_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } qe_t;

    fl_t         infl[$];
    qe_t         expq[$];
    logic [31:0] exp_fetch;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_count = 0;
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          got_cyc[$];

    logic        obs_req_valid, obs_if_valid, obs_idle;
    logic [31:0] obs_addr, obs_if_pc, obs_if_inst;
    logic        exp_req_valid, exp_if_valid, exp_idle;
    logic [31:0] exp_addr, exp_pc, exp_inst;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock: memory drives responses, outputs are sampled at negedge, model advances at posedge.
    task automatic cycle();
        fl_t f;
        if (!rst && infl.size() > 0 && infl[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(infl[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_if_valid  = if_valid;
        obs_if_pc     = if_pc;
        obs_if_inst   = if_inst;
        obs_idle      = if_idle;
        exp_req_valid = !rst && !redirect_valid && (expq.size() + infl.size() < QDEPTH);
        exp_addr      = exp_fetch;
        exp_if_valid  = (expq.size() != 0);
        exp_pc        = '0;
        exp_inst      = '0;
        if (exp_if_valid) begin
            exp_pc   = expq[0].pc;
            exp_inst = expq[0].inst;
        end
        exp_idle = (expq.size() == 0) && (infl.size() == 0);
        @(posedge clk);
        if (rst) begin
            expq.delete();
            infl.delete();
            exp_fetch = RESET_PC;
        end else begin
            if (!redirect_valid && obs_if_valid && if_ready) begin
                got_pc.push_back(obs_if_pc);
                got_inst.push_back(obs_if_inst);
                got_cyc.push_back(cyc);
            end
            if (!redirect_valid && expq.size() > 0 && if_ready) void'(expq.pop_front());
            if (imem_rsp_valid && infl.size() > 0) begin
                f = infl.pop_front();
                if (!f.stale && !redirect_valid) expq.push_back('{pc: f.pc, inst: inst_of(f.pc)});
            end
            if (obs_req_valid && imem_req_ready) begin
                infl.push_back('{pc: exp_fetch, addr: obs_addr,
                                 due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
                exp_fetch = exp_fetch + 32'd4;
                acc_count++;
            end
            if (redirect_valid) begin
                foreach (infl[i]) infl[i].stale = 1'b1;
                expq.delete();
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        got_pc.delete(); got_inst.delete(); got_cyc.delete();
        acc_count = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid_in_rst: got %b expected 0", obs_req_valid); end
        rst = 1'b0;
        cycle();
        n_cmp++; if (obs_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 1", obs_req_valid); end
        n_cmp++; if (obs_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", obs_addr, RESET_PC); end
        n_cmp++; if (obs_if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", obs_if_valid); end
        n_cmp++; if (obs_if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h expected 0", obs_if_pc); end
        n_cmp++; if (obs_if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst: got %h expected 0", obs_if_inst); end
        n_cmp++; if (obs_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", obs_idle); end
    endtask

    task automatic test_in_order();
        int s;
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        s = cyc;
        repeat (10) cycle();
        n_cmp++;
        if (got_pc.size() < 3) begin
            n_fail++; $display("FAIL inorder_count: got %0d expected >=3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_pc[i] !== RESET_PC + 32'(4 * i)) begin
                    n_fail++; $display("FAIL inorder_pc%0d: got %h expected %h", i, got_pc[i], RESET_PC + 32'(4 * i));
                end
                n_cmp++;
                if (got_inst[i] !== inst_of(RESET_PC + 32'(4 * i))) begin
                    n_fail++; $display("FAIL inorder_inst%0d: got %h expected %h", i, got_inst[i], inst_of(RESET_PC + 32'(4 * i)));
                end
            end
            n_cmp++;
            if (got_cyc[0] !== s + 2) begin
                n_fail++; $display("FAIL inorder_first_latency: got cycle %0d expected %0d", got_cyc[0] - s, 2);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        repeat (10) cycle();
        n_cmp++; if (acc_count !== 2) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 2", acc_count); end
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b expected 0", obs_req_valid); end
        n_cmp++; if (obs_if_pc !== RESET_PC) begin n_fail++; $display("FAIL stall_head_pc: got %h expected %h", obs_if_pc, RESET_PC); end
        if_ready = 1'b1;
        repeat (12) cycle();
        n_cmp++;
        if (got_pc.size() < 4) begin
            n_fail++; $display("FAIL stall_resume_count: got %0d expected >=4", got_pc.size());
        end
        foreach (got_pc[i]) begin
            n_cmp++;
            if (got_pc[i] !== RESET_PC + 32'(4 * i)) begin
                n_fail++; $display("FAIL stall_resume_pc%0d: got %h expected %h", i, got_pc[i], RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++; if (acc_count !== 2) begin n_fail++; $display("FAIL drain_outstanding: got %0d expected 2", acc_count); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        cycle();
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_req_in_redirect: got %b expected 0", obs_req_valid); end
        redirect_valid = 1'b0;
        repeat (16) cycle();
        n_cmp++;
        if (got_pc.size() < 2) begin
            n_fail++; $display("FAIL drain_count: got %0d expected >=2", got_pc.size());
        end else begin
            n_cmp++; if (got_pc[0] !== 32'h8000_0100) begin n_fail++; $display("FAIL drain_first_pc: got %h expected 80000100", got_pc[0]); end
            n_cmp++; if (got_pc[1] !== 32'h8000_0104) begin n_fail++; $display("FAIL drain_second_pc: got %h expected 80000104", got_pc[1]); end
            n_cmp++; if (got_inst[0] !== inst_of(32'h8000_0100)) begin n_fail++; $display("FAIL drain_first_inst: got %h expected %h", got_inst[0], inst_of(32'h8000_0100)); end
        end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        cycle();
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL collide_req_valid: got %b expected 0", obs_req_valid); end
        n_cmp++; if (obs_if_valid !== 1'b1) begin n_fail++; $display("FAIL collide_head_valid: got %b expected 1", obs_if_valid); end
        redirect_valid = 1'b0;
        cycle();
        n_cmp++; if (obs_if_valid !== 1'b0) begin n_fail++; $display("FAIL collide_flushed: got %b expected 0", obs_if_valid); end
        n_cmp++; if (obs_idle !== 1'b1) begin n_fail++; $display("FAIL collide_idle: got %b expected 1", obs_idle); end
        n_cmp++; if (obs_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL collide_addr: got %h expected 80000200", obs_addr); end
        repeat (8) cycle();
        n_cmp++;
        if (got_pc.size() < 2) begin
            n_fail++; $display("FAIL collide_count: got %0d expected >=2", got_pc.size());
        end else begin
            n_cmp++; if (got_pc[0] !== 32'h8000_0200) begin n_fail++; $display("FAIL collide_first_pc: got %h expected 80000200", got_pc[0]); end
            n_cmp++; if (got_pc[1] !== 32'h8000_0204) begin n_fail++; $display("FAIL collide_second_pc: got %h expected 80000204", got_pc[1]); end
        end
    endtask

    task automatic test_align_wrap();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        n_cmp++; if (obs_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL align_addr: got %h expected 80000100", obs_addr); end
        repeat (6) cycle();
        n_cmp++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h8000_0100) begin
            n_fail++; $display("FAIL align_first_pc: got %h expected 80000100", (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        got_pc.delete(); got_inst.delete(); got_cyc.delete();
        repeat (10) cycle();
        n_cmp++;
        if (got_pc.size() < 3) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected >=3", got_pc.size());
        end else begin
            n_cmp++; if (got_pc[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h expected fffffffc", got_pc[0]); end
            n_cmp++; if (got_pc[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc1: got %h expected 00000000", got_pc[1]); end
            n_cmp++; if (got_pc[2] !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_pc2: got %h expected 00000004", got_pc[2]); end
            n_cmp++; if (got_inst[1] !== inst_of(32'h0)) begin n_fail++; $display("FAIL wrap_inst1: got %h expected %h", got_inst[1], inst_of(32'h0)); end
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b0; if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (obs_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid%0d: got %b expected 1", i, obs_req_valid); end
            n_cmp++; if (obs_addr !== RESET_PC) begin n_fail++; $display("FAIL hold_addr%0d: got %h expected %h", i, obs_addr, RESET_PC); end
        end
        imem_req_ready = 1'b1;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        n_cmp++; if (obs_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b expected 0", obs_req_valid); end
        rst = 1'b0;
        cycle();
        n_cmp++; if (obs_if_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_if_valid: got %b expected 0", obs_if_valid); end
        n_cmp++; if (obs_if_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_if_pc: got %h expected 0", obs_if_pc); end
        n_cmp++; if (obs_if_inst !== 32'h0) begin n_fail++; $display("FAIL midrst_if_inst: got %h expected 0", obs_if_inst); end
        n_cmp++; if (obs_idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b expected 1", obs_idle); end
        n_cmp++; if (obs_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst_addr: got %h expected %h", obs_addr, RESET_PC); end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            imem_req_ready = ($urandom_range(0, 9) < 7);
            if_ready       = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            cycle();
            n_cmp++; if (obs_req_valid !== exp_req_valid) begin n_fail++; $display("FAIL rnd_req_valid@%0d: got %b expected %b", n, obs_req_valid, exp_req_valid); end
            n_cmp++; if (exp_req_valid && obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", n, obs_addr, exp_addr); end
            n_cmp++; if (obs_if_valid !== exp_if_valid) begin n_fail++; $display("FAIL rnd_if_valid@%0d: got %b expected %b", n, obs_if_valid, exp_if_valid); end
            n_cmp++; if (exp_if_valid && (obs_if_pc !== exp_pc || obs_if_inst !== exp_inst)) begin
                n_fail++; $display("FAIL rnd_head@%0d: got %h/%h expected %h/%h", n, obs_if_pc, obs_if_inst, exp_pc, exp_inst);
            end
            n_cmp++; if (obs_idle !== exp_idle) begin n_fail++; $display("FAIL rnd_idle@%0d: got %b expected %b", n, obs_idle, exp_idle); end
        end
        rst = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        exp_fetch = RESET_PC;
        @(posedge clk);
        #1;
        test_reset();
        test_in_order();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collision();
        test_align_wrap();
        test_stall_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
